vend_panel_arbiter: RTL

- Shares one vending core (single price/change datapath) between two customer front panels.
- Grants one panel a purchase session at a time, round-robin.
- During a session: issues the item-select pulse to the core, then forwards only the granted panel's coin pulses. Coins from the other panel are rejected.
- Watches the core's item-release and change-return outputs to detect end of session, then re-arbitrates.

---
 rtl/vend_panel_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vend_panel_arbiter.sv
// vend_panel_arbiter: round-robin session arbiter that shares one vending core
// between two customer panels. It grants a session, selects the item on the core,
// forwards the granted panel's coins and closes the session on release/change return.
// Optional feature: define VEND_ARB_TIMEOUT_EN to abandon PAY sessions that see no
// accepted coin for TIMEOUT_CYC cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no session; arbitrate pending requests
// S_SEL     | one-cycle item-select pulse to the core
// S_PAY     | forward granted panel's coins, wait for item release
// S_SETTLE  | one cycle after release; sample change-return
// S_RC_WAIT | core still returning change
module vend_panel_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] item0,
    input  logic [1:0] item1,
    input  logic [1:0] dollar_10,
    input  logic [1:0] dollar_50,
    input  logic [2:0] core_item_rels,
    input  logic       core_change_return,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       core_sel,
    output logic [1:0] core_item,
    output logic       core_dollar_10,
    output logic       core_dollar_50,
    output logic [1:0] coin_reject,
    output logic [1:0] vend_done,
    output logic       timeout_abort
);

    if (2 ** CNT_W <= TIMEOUT_CYC) begin : g_cfg_err
        $error("CNT_W too narrow to hold TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_PAY, S_SETTLE, S_RC_WAIT} state_t;

    state_t     state, state_nx;
    logic       last_grant, last_grant_nx;   // also the owner of the current session
    logic       coin_seen, coin_seen_nx;
    logic [1:0] gnt_nx, core_item_nx, coin_reject_nx, vend_done_nx;
    logic       busy_nx, core_sel_nx, dollar_10_nx, dollar_50_nx;
    logic       win, in_pay, own_10, own_50, own_req, coin_ok;
    logic       unused_rels;

    assign unused_rels = ^core_item_rels[1:0];

    assign in_pay  = (state == S_PAY);
    assign own_10  = dollar_10[last_grant];
    assign own_50  = dollar_50[last_grant];
    assign own_req = req[last_grant];
    // A simultaneous 10+50 pulse is ambiguous and is bounced rather than forwarded.
    assign coin_ok = in_pay & (own_10 ^ own_50);

`ifdef VEND_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
    logic             abort_nx;
`endif

    // Next-state and next-output decode for the session FSM.
    always_comb begin
        state_nx       = state;
        last_grant_nx  = last_grant;
        coin_seen_nx   = coin_seen;
        gnt_nx         = gnt;
        core_sel_nx    = 1'b0;
        core_item_nx   = core_item;
        dollar_10_nx   = 1'b0;
        dollar_50_nx   = 1'b0;
        vend_done_nx   = 2'b00;
        win            = 1'b0;
`ifdef VEND_ARB_TIMEOUT_EN
        idle_cnt_nx    = '0;
        abort_nx       = 1'b0;
`endif
        coin_reject_nx[0] = (dollar_10[0] | dollar_50[0]) &
                            ~(in_pay & ~last_grant & (dollar_10[0] ^ dollar_50[0]));
        coin_reject_nx[1] = (dollar_10[1] | dollar_50[1]) &
                            ~(in_pay & last_grant & (dollar_10[1] ^ dollar_50[1]));

        case (state)
            S_IDLE: begin
                coin_seen_nx = 1'b0;
                if (|req) begin
                    win           = (req == 2'b11) ? ~last_grant : req[1];
                    state_nx      = S_SEL;
                    last_grant_nx = win;
                    gnt_nx        = win ? 2'b10 : 2'b01;
                    core_sel_nx   = 1'b1;
                    core_item_nx  = win ? item1 : item0;
                end
            end
            S_SEL: state_nx = S_PAY;
            S_PAY: begin
                if (coin_ok) begin
                    dollar_10_nx = own_10;
                    dollar_50_nx = own_50;
                    coin_seen_nx = 1'b1;
                end
                // A coin arriving with the request drop keeps the session alive.
                if (core_item_rels[2]) begin
                    state_nx = S_SETTLE;
                end else if (!own_req && !coin_seen && !coin_ok) begin
                    state_nx = S_IDLE;
                    gnt_nx   = 2'b00;
                end
`ifdef VEND_ARB_TIMEOUT_EN
                else if (!coin_seen && !coin_ok) begin
                    if (idle_cnt == CNT_LAST) begin
                        state_nx = S_IDLE;
                        gnt_nx   = 2'b00;
                        abort_nx = 1'b1;
                    end else begin
                        idle_cnt_nx = idle_cnt + CNT_W'(1);
                    end
                end
`endif
            end
            S_SETTLE: begin
                if (core_change_return) begin
                    state_nx = S_RC_WAIT;
                end else begin
                    state_nx     = S_IDLE;
                    gnt_nx       = 2'b00;
                    vend_done_nx = last_grant ? 2'b10 : 2'b01;
                end
            end
            S_RC_WAIT: begin
                if (!core_change_return) begin
                    state_nx     = S_IDLE;
                    gnt_nx       = 2'b00;
                    vend_done_nx = last_grant ? 2'b10 : 2'b01;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // State and registered outputs; reset parks the arbiter so panel 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            coin_seen      <= 1'b0;
            gnt            <= 2'b00;
            busy           <= 1'b0;
            core_sel       <= 1'b0;
            core_item      <= 2'b00;
            core_dollar_10 <= 1'b0;
            core_dollar_50 <= 1'b0;
            coin_reject    <= 2'b00;
            vend_done      <= 2'b00;
        end else begin
            state          <= state_nx;
            last_grant     <= last_grant_nx;
            coin_seen      <= coin_seen_nx;
            gnt            <= gnt_nx;
            busy           <= busy_nx;
            core_sel       <= core_sel_nx;
            core_item      <= core_item_nx;
            core_dollar_10 <= dollar_10_nx;
            core_dollar_50 <= dollar_50_nx;
            coin_reject    <= coin_reject_nx;
            vend_done      <= vend_done_nx;
        end
    end

`ifdef VEND_ARB_TIMEOUT_EN
    // No-coin timer for PAY and its abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt      <= '0;
            timeout_abort <= 1'b0;
        end else begin
            idle_cnt      <= idle_cnt_nx;
            timeout_abort <= abort_nx;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

endmodule
